// File: rtl/clarvi_slice_sequencer.sv
// Slice sequencer for the clarvi DE stage: steps one instruction through XLEN/SLICE_W
// datapath slices, forwards operand slices from later stages and raises sequencing stalls.
module clarvi_slice_sequencer #(
  parameter int XLEN    = 64,
  parameter int SLICE_W = 16,
  parameter int NUM_FWD = 3,
  parameter int REG_W   = 5,
  parameter int PART_W  = $clog2(XLEN / SLICE_W)
) (
  input  logic                         i_clock,
  input  logic                         i_reset,
  input  logic                         i_in_valid,
  input  logic                         i_stall_stage,
  input  logic                         i_flush,
  input  logic                         i_order_desc,
  input  logic                         i_word_op,
  input  logic [REG_W-1:0]             i_rs1,
  input  logic [REG_W-1:0]             i_rs2,
  input  logic                         i_rs1_used,
  input  logic                         i_rs2_used,
  input  logic [SLICE_W-1:0]           i_rs1_fetched,
  input  logic [SLICE_W-1:0]           i_rs2_fetched,
  input  logic [NUM_FWD-1:0]           i_fwd_valid,
  input  logic [NUM_FWD-1:0]           i_fwd_is_load,
  input  logic [NUM_FWD*REG_W-1:0]     i_fwd_rd,
  input  logic [NUM_FWD*PART_W-1:0]    i_fwd_part,
  input  logic [NUM_FWD*SLICE_W-1:0]   i_fwd_value,
  input  logic                         i_mem_address_error,
  output logic [PART_W-1:0]            o_seq_idx,
  output logic [PART_W-1:0]            o_exec_part,
  output logic                         o_first_part,
  output logic                         o_last_part,
  output logic [SLICE_W-1:0]           o_rs1_value,
  output logic [SLICE_W-1:0]           o_rs2_value,
  output logic                         o_stall_for_parts,
  output logic                         o_stall_for_load_dep
);

  localparam int PARTS = XLEN / SLICE_W;
  localparam logic [PART_W-1:0] LAST_IDX = PART_W'(PARTS - 1);

  logic [PART_W-1:0]  r_seq_idx;
  logic [PART_W-1:0]  w_seq_next;
  logic [PART_W-1:0]  w_exec_part;
  logic [PART_W-1:0]  w_word_rev;
  logic               w_last_part;
  logic [NUM_FWD-1:0] w_fwd_ok;
  logic [REG_W-1:0]   w_fwd_rd    [NUM_FWD];
  logic [PART_W-1:0]  w_fwd_part  [NUM_FWD];
  logic [SLICE_W-1:0] w_fwd_value [NUM_FWD];
  logic               w_rs1_dep;
  logic               w_rs2_dep;

  assign w_last_part = (r_seq_idx == LAST_IDX);

  always_comb begin
    w_seq_next = r_seq_idx;
    if (!i_stall_stage) begin
      if (!i_in_valid || w_last_part) begin
        w_seq_next = '0;
      end else begin
        w_seq_next = r_seq_idx + PART_W'(1);
      end
    end
  end

  // Flush outranks stall so a killed instruction never leaves a half-sequenced index behind.
  always_ff @(posedge i_clock) begin
    if (i_reset || i_flush) begin
      r_seq_idx <= '0;
    end else begin
      r_seq_idx <= w_seq_next;
    end
  end

  // Word ops descend within each 32-bit half; with only two slices there is no lower bit to flip.
  generate
    if (PART_W > 1) begin : g_word_rev
      assign w_word_rev = {r_seq_idx[PART_W-1], ~r_seq_idx[PART_W-2:0]};
    end else begin : g_word_rev_narrow
      assign w_word_rev = r_seq_idx;
    end
  endgenerate

  always_comb begin
    w_exec_part = r_seq_idx;
    if (i_order_desc) begin
      if (i_word_op) begin
        w_exec_part = w_word_rev;
      end else begin
        w_exec_part = LAST_IDX - r_seq_idx;
      end
    end
  end

  // A load in EX has no data yet, so channel 0 may only forward non-load results.
  generate
    for (genvar gk = 0; gk < NUM_FWD; gk++) begin : g_fwd
      localparam bit IS_EX = (gk == 0);
      assign w_fwd_rd[gk]    = i_fwd_rd[gk*REG_W +: REG_W];
      assign w_fwd_part[gk]  = i_fwd_part[gk*PART_W +: PART_W];
      assign w_fwd_value[gk] = i_fwd_value[gk*SLICE_W +: SLICE_W];
      assign w_fwd_ok[gk]    = i_fwd_valid[gk] && (w_fwd_part[gk] == w_exec_part)
                               && !(IS_EX && i_fwd_is_load[gk]);
    end
  endgenerate

  // Walk from oldest to nearest so the lowest matching channel is the last writer.
  always_comb begin
    o_rs1_value = i_rs1_fetched;
    o_rs2_value = i_rs2_fetched;
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (w_fwd_ok[k] && (w_fwd_rd[k] == i_rs1)) begin
        o_rs1_value = w_fwd_value[k];
      end
      if (w_fwd_ok[k] && (w_fwd_rd[k] == i_rs2)) begin
        o_rs2_value = w_fwd_value[k];
      end
    end
  end

  assign w_rs1_dep = i_rs1_used && (w_fwd_rd[0] == i_rs1);
  assign w_rs2_dep = i_rs2_used && (w_fwd_rd[0] == i_rs2);

  assign o_stall_for_load_dep = i_in_valid && i_fwd_valid[0] && i_fwd_is_load[0]
                                && !i_mem_address_error && (w_rs1_dep || w_rs2_dep)
                                && (w_fwd_part[0] == w_exec_part);

  assign o_seq_idx         = r_seq_idx;
  assign o_exec_part       = w_exec_part;
  assign o_first_part      = (r_seq_idx == '0);
  assign o_last_part       = w_last_part;
  assign o_stall_for_parts = i_in_valid && !w_last_part;

endmodule

// File: tb/tb_clarvi_slice_sequencer.sv
// Bench for clarvi_slice_sequencer: table of per-cycle vectors checked through a scoreboard
// queue, plus a short hand-written run on a two-slice instance.
module tb_clarvi_slice_sequencer;

  typedef struct {
    logic        rst, valid, stall, fsh, desc, word;
    logic [4:0]  r1, r2;
    logic        u1, u2;
    logic [2:0]  fv, fload;
    logic [14:0] frd;
    logic [5:0]  fpart;
    logic [47:0] fval;
    logic        merr;
    logic [1:0]  eSeq, eExec;
    logic        eFirst, eLast, eParts, eLoad;
    logic [15:0] eRs1, eRs2;
  } vecT;

  typedef struct {
    logic        eSeq, eExec, eParts, eLast;
    logic [31:0] eRs1;
  } vec2T;

  logic clock = 1'b0;
  logic reset, inValid, stallStage, flush, orderDesc, wordOp;
  logic [4:0]  rs1, rs2;
  logic        rs1Used, rs2Used;
  logic [15:0] rs1Fetched, rs2Fetched;
  logic [2:0]  fwdValid, fwdIsLoad;
  logic [14:0] fwdRd;
  logic [5:0]  fwdPart;
  logic [47:0] fwdValue;
  logic        memErr;
  logic [1:0]  seqIdx, execPart;
  logic        firstPart, lastPart, stallParts, stallLoad;
  logic [15:0] rs1Value, rs2Value;

  logic [2:0]  zero3 = 3'b000;
  logic [95:0] zero96 = '0;
  logic [31:0] fetch2a = 32'hCAFE_F00D;
  logic [31:0] fetch2b = 32'h0BAD_BEEF;
  logic        seqIdx2, execPart2, firstPart2, lastPart2, stallParts2, stallLoad2;
  logic [31:0] rs1Value2, rs2Value2;

  int checks = 0;
  int failures = 0;
  vecT  tbl[$];
  vecT  expQ[$];
  vec2T q2[$];

  always #5 clock = ~clock;

  clarvi_slice_sequencer dut (
    .i_clock(clock), .i_reset(reset), .i_in_valid(inValid), .i_stall_stage(stallStage),
    .i_flush(flush), .i_order_desc(orderDesc), .i_word_op(wordOp),
    .i_rs1(rs1), .i_rs2(rs2), .i_rs1_used(rs1Used), .i_rs2_used(rs2Used),
    .i_rs1_fetched(rs1Fetched), .i_rs2_fetched(rs2Fetched),
    .i_fwd_valid(fwdValid), .i_fwd_is_load(fwdIsLoad), .i_fwd_rd(fwdRd),
    .i_fwd_part(fwdPart), .i_fwd_value(fwdValue), .i_mem_address_error(memErr),
    .o_seq_idx(seqIdx), .o_exec_part(execPart), .o_first_part(firstPart),
    .o_last_part(lastPart), .o_rs1_value(rs1Value), .o_rs2_value(rs2Value),
    .o_stall_for_parts(stallParts), .o_stall_for_load_dep(stallLoad)
  );

  clarvi_slice_sequencer #(.SLICE_W(32)) dut2 (
    .i_clock(clock), .i_reset(reset), .i_in_valid(inValid), .i_stall_stage(stallStage),
    .i_flush(flush), .i_order_desc(orderDesc), .i_word_op(wordOp),
    .i_rs1(rs1), .i_rs2(rs2), .i_rs1_used(rs1Used), .i_rs2_used(rs2Used),
    .i_rs1_fetched(fetch2a), .i_rs2_fetched(fetch2b),
    .i_fwd_valid(zero3), .i_fwd_is_load(zero3), .i_fwd_rd(fwdRd),
    .i_fwd_part(zero3), .i_fwd_value(zero96), .i_mem_address_error(memErr),
    .o_seq_idx(seqIdx2), .o_exec_part(execPart2), .o_first_part(firstPart2),
    .o_last_part(lastPart2), .o_rs1_value(rs1Value2), .o_rs2_value(rs2Value2),
    .o_stall_for_parts(stallParts2), .o_stall_for_load_dep(stallLoad2)
  );

  function automatic vecT mk(input logic valid, stall, fsh, desc, word, rst,
                             input int eSeq, eExec, input logic eParts);
    vecT v;
    v.rst = rst; v.valid = valid; v.stall = stall; v.fsh = fsh; v.desc = desc; v.word = word;
    v.r1 = '0; v.r2 = '0; v.u1 = 1'b0; v.u2 = 1'b0;
    v.fv = '0; v.fload = '0; v.frd = '0; v.fpart = '0; v.fval = '0; v.merr = 1'b0;
    v.eSeq = 2'(eSeq); v.eExec = 2'(eExec);
    v.eFirst = (eSeq == 0); v.eLast = (eSeq == 3);
    v.eParts = eParts; v.eLoad = 1'b0;
    v.eRs1 = 16'h1111; v.eRs2 = 16'h2222;
    return v;
  endfunction

  task automatic checkField(input string nm, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic applyStimulus(input vecT v);
    reset = v.rst; inValid = v.valid; stallStage = v.stall; flush = v.fsh;
    orderDesc = v.desc; wordOp = v.word;
    rs1 = v.r1; rs2 = v.r2; rs1Used = v.u1; rs2Used = v.u2;
    fwdValid = v.fv; fwdIsLoad = v.fload; fwdRd = v.frd; fwdPart = v.fpart;
    fwdValue = v.fval; memErr = v.merr;
    expQ.push_back(v);
  endtask

  task automatic checkOutput(input int row);
    vecT e;
    checks++;
    if (expQ.size() == 0) begin
      failures++;
      $display("[TB] FAIL row%0d scoreboard: got empty queue expected entry", row);
    end else begin
      e = expQ.pop_front();
      checkField($sformatf("row%0d seq_idx", row), 48'(seqIdx), 48'(e.eSeq));
      checkField($sformatf("row%0d exec_part", row), 48'(execPart), 48'(e.eExec));
      checkField($sformatf("row%0d first_part", row), 48'(firstPart), 48'(e.eFirst));
      checkField($sformatf("row%0d last_part", row), 48'(lastPart), 48'(e.eLast));
      checkField($sformatf("row%0d stall_for_parts", row), 48'(stallParts), 48'(e.eParts));
      checkField($sformatf("row%0d stall_for_load_dep", row), 48'(stallLoad), 48'(e.eLoad));
      checkField($sformatf("row%0d rs1_value", row), 48'(rs1Value), 48'(e.eRs1));
      checkField($sformatf("row%0d rs2_value", row), 48'(rs2Value), 48'(e.eRs2));
    end
  endtask

  task automatic stepTwo(input logic desc, input logic eSeq, eExec, eParts, eLast, input int row);
    vec2T e;
    inValid = 1'b1; stallStage = 1'b0; flush = 1'b0; orderDesc = desc; wordOp = 1'b0;
    q2.push_back('{eSeq, eExec, eParts, eLast, 32'hCAFE_F00D});
    @(negedge clock);
    e = q2.pop_front();
    checkField($sformatf("two%0d seq_idx", row), 48'(seqIdx2), 48'(e.eSeq));
    checkField($sformatf("two%0d exec_part", row), 48'(execPart2), 48'(e.eExec));
    checkField($sformatf("two%0d stall_for_parts", row), 48'(stallParts2), 48'(e.eParts));
    checkField($sformatf("two%0d last_part", row), 48'(lastPart2), 48'(e.eLast));
    checkField($sformatf("two%0d rs1_value", row), 48'(rs1Value2), 48'(e.eRs1));
    @(posedge clock); #1;
  endtask

  initial begin
    vecT v;
    rs1Fetched = 16'h1111; rs2Fetched = 16'h2222;

    // Plain ascending, descending and word-descending sequences.
    tbl.push_back(mk(0,0,0,0,0,0, 0,0,0));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(1,0,0,0,0,0, i, i, i != 3));
    tbl.push_back(mk(0,0,0,0,0,0, 0,0,0));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(1,0,0,1,0,0, i, 3 - i, i != 3));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(1,0,0,1,1,0, i, i ^ 1, i != 3));
    // Stall hold at seq_idx 2.
    tbl.push_back(mk(1,0,0,0,0,0, 0,0,1));
    tbl.push_back(mk(1,0,0,0,0,0, 1,1,1));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(1,1,0,0,0,0, 2,2,1));
    tbl.push_back(mk(1,0,0,0,0,0, 2,2,1));
    tbl.push_back(mk(1,0,0,0,0,0, 3,3,0));
    // Reset beats stall at seq_idx 2.
    tbl.push_back(mk(1,0,0,0,0,0, 0,0,1));
    tbl.push_back(mk(1,0,0,0,0,0, 1,1,1));
    tbl.push_back(mk(1,1,0,0,0,1, 2,2,1));
    // Flush on last_part, then flush beats stall.
    for (int i = 0; i < 3; i++) tbl.push_back(mk(1,0,0,0,0,0, i, i, 1));
    tbl.push_back(mk(1,0,1,0,0,0, 3,3,0));
    tbl.push_back(mk(1,0,0,0,0,0, 0,0,1));
    tbl.push_back(mk(1,0,0,0,0,0, 1,1,1));
    tbl.push_back(mk(1,1,1,0,0,0, 2,2,1));
    tbl.push_back(mk(0,0,0,0,0,0, 0,0,0));
    // in_valid dropping mid-sequence.
    tbl.push_back(mk(1,0,0,0,0,0, 0,0,1));
    tbl.push_back(mk(0,0,0,0,0,0, 1,1,0));
    tbl.push_back(mk(0,0,0,0,0,0, 0,0,0));
    // Forwarding priority with exec_part held at 1.
    tbl.push_back(mk(1,0,0,0,0,0, 0,0,1));
    v = mk(1,1,0,0,0,0, 1,1,1);
    v.r1 = 5'd5; v.u1 = 1'b1; v.fv = 3'b101;
    v.frd = {5'd5, 5'd0, 5'd5}; v.fpart = {2'd1, 2'd0, 2'd1};
    v.fval = {16'hBBBB, 16'hCCCC, 16'hAAAA}; v.eRs1 = 16'hAAAA;
    tbl.push_back(v);
    v.fpart = {2'd1, 2'd0, 2'd2}; v.eRs1 = 16'hBBBB;
    tbl.push_back(v);
    v.fv = 3'b000; v.eRs1 = 16'h1111;
    tbl.push_back(v);
    v.fv = 3'b110; v.frd = {5'd5, 5'd5, 5'd5}; v.fpart = {2'd1, 2'd1, 2'd1}; v.eRs1 = 16'hCCCC;
    tbl.push_back(v);
    tbl.push_back(mk(1,0,0,0,0,0, 1,1,1));
    tbl.push_back(mk(1,0,0,0,0,0, 2,2,1));
    tbl.push_back(mk(1,0,0,0,0,0, 3,3,0));
    // Load dependency on channel 0.
    v = mk(1,1,0,0,0,0, 0,0,1);
    v.r1 = 5'd3; v.r2 = 5'd7; v.u2 = 1'b1; v.fv = 3'b001; v.fload = 3'b001;
    v.frd = {5'd0, 5'd0, 5'd7}; v.fval = {16'h0, 16'h0, 16'hDDDD}; v.eLoad = 1'b1;
    tbl.push_back(v);
    v.merr = 1'b1; v.eLoad = 1'b0;
    tbl.push_back(v);
    v.merr = 1'b0; v.stall = 1'b0; v.eLoad = 1'b1;
    tbl.push_back(v);
    v.stall = 1'b1; v.eSeq = 2'd1; v.eExec = 2'd1; v.eFirst = 1'b0; v.eLoad = 1'b0;
    tbl.push_back(v);
    v.fpart = {2'd0, 2'd0, 2'd1}; v.u2 = 1'b0;
    tbl.push_back(v);
    v.u2 = 1'b1; v.eLoad = 1'b1;
    tbl.push_back(v);
    v.valid = 1'b0; v.eParts = 1'b0; v.eLoad = 1'b0;
    tbl.push_back(v);
    v.valid = 1'b1; v.eParts = 1'b1; v.r1 = 5'd7; v.u1 = 1'b1; v.u2 = 1'b0; v.eLoad = 1'b1;
    tbl.push_back(v);
    v.fload = 3'b000; v.eLoad = 1'b0; v.eRs1 = 16'hDDDD; v.eRs2 = 16'hDDDD;
    tbl.push_back(v);
    v = mk(0,0,0,0,0,0, 1,1,0);
    tbl.push_back(v);

    applyStimulus(mk(0,0,0,0,0,1, 0,0,0));
    void'(expQ.pop_front());
    repeat (2) @(posedge clock);
    #1;

    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i]);
      @(negedge clock);
      checkOutput(i);
      @(posedge clock); #1;
    end

    reset = 1'b1; inValid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    stepTwo(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0);
    stepTwo(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1);
    stepTwo(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2);
    stepTwo(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clarvi_slice_sequencer.md
Name: clarvi_slice_sequencer

Overview:
- Parametrised successor to the fixed 4-part decode sequencer.
- Sequences one architectural instruction held in DE through XLEN/SLICE_W datapath slices, in ascending or descending slice order.
- Resolves per-slice operand forwarding from NUM_FWD later pipeline stages and raises slice-sequencing and load-dependency stalls.
- Sits between instruction decode and the DE/EX pipeline register.

Parameters:
- XLEN, 64, architectural register width.
- SLICE_W, 16, datapath slice width. XLEN/SLICE_W = PARTS must be a power of two and at least 2.
- NUM_FWD, 3, number of forwarding sources. Index 0 is the nearest stage (EX); higher indices are older stages.
- REG_W, 5, register index width.
- PART_W, $clog2(XLEN/SLICE_W), slice index width (derived; do not override).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  DE stage holds a valid instruction
- stall_stage  in  1  freeze DE (any pipeline stall, including this block's own stall outputs, combined externally)
- flush  in  1  kill the instruction in DE; restart sequencing
- order_desc  in  1  instruction needs most-significant slice first (SRL, SRA, SLT, SLTU, BLT, BLTU, BGE, BGEU)
- word_op  in  1  32-bit (*W) operation
- rs1, rs2  in  REG_W each  source register indices
- rs1_used, rs2_used  in  1 each  source is read (already 0 for x0)
- rs1_fetched, rs2_fetched  in  SLICE_W each  register-file slice read at exec_part
- fwd_valid  in  NUM_FWD  stage k is valid and writes back
- fwd_is_load  in  NUM_FWD  stage k is a load
- fwd_rd  in  NUM_FWD*REG_W  destination index of stage k
- fwd_part  in  NUM_FWD*PART_W  slice index held by stage k
- fwd_value  in  NUM_FWD*SLICE_W  result slice of stage k
- mem_address_error  in  1  load in stage 0 faults; suppresses the load-dependency stall
- seq_idx  out  PART_W  sequence step (0..PARTS-1)
- exec_part  out  PART_W  physical slice processed this cycle
- first_part, last_part  out  1 each  seq_idx==0 / seq_idx==PARTS-1
- rs1_value, rs2_value  out  SLICE_W each  forwarded operands
- stall_for_parts  out  1  more slices remain for this instruction
- stall_for_load_dep  out  1  operand slice is not yet available from a load

Behaviour:
- State: the seq_idx register only. Reset and flush both force it to 0. Both take priority over stall_stage.
- Advance rule, evaluated when stall_stage=0:
  - !in_valid → 0
  - seq_idx==PARTS-1 → 0
  - otherwise seq_idx+1, wrapping to 0 after PARTS-1.
- stall_stage=1 holds seq_idx.
- stall_for_parts = in_valid && !last_part. This is combinational, zero latency.
- exec_part mapping (combinational):
  - !order_desc → seq_idx.
  - order_desc && !word_op → PARTS-1-seq_idx.
  - order_desc && word_op → reverse within each half: MSB kept, lower PART_W-1 bits inverted. For PARTS=4 this gives 1,0,3,2.
- Forwarding, per source s ∈ {rs1, rs2}:
  - Channel k matches when fwd_valid[k] && fwd_rd[k]==s && fwd_part[k]==exec_part && !(k==0 && fwd_is_load[0]).
  - The lowest matching k wins. With no match, the value comes from *_fetched.
  - If the source is unused, the value is still driven (don't-care for consumers).
- stall_for_load_dep = in_valid && fwd_valid[0] && fwd_is_load[0] && !mem_address_error && ((rs1_used && fwd_rd[0]==rs1) || (rs2_used && fwd_rd[0]==rs2)) && fwd_part[0]==exec_part.
- Outputs after reset: seq_idx=0, exec_part=0 (desc: PARTS-1 when in_valid and order_desc), first_part=1, last_part=0, stalls=0 while in_valid=0.
- A flush asserted on the same cycle as last_part leaves seq_idx at 0. No slice is double-issued.
- in_valid dropping mid-sequence returns seq_idx to 0 on the next unstalled edge.

Test Plan:
- Defaults, ADD, in_valid=1, no stalls → exec_part 0,1,2,3; stall_for_parts=1,1,1,0; then back to 0.
- order_desc=1 → exec_part 3,2,1,0. Add word_op=1 → 1,0,3,2. Repeat with SLICE_W=32 → 1,0.
- stall_stage high at seq_idx=2 for 3 cycles → seq_idx holds at 2. Reset asserted at seq_idx=2 → 0 next edge. flush at last_part → 0, next instruction starts at 0.
- rs1=5, exec_part=1, channels 0 and 2 both rd=5 part=1 values 0xAAAA/0xBBBB → rs1_value=0xAAAA. With channel 0 part=2 → 0xBBBB. With no match → rs1_fetched.
- Channel 0 load rd=7 part=0, rs2=7 used, exec_part=0 → stall_for_load_dep=1, and channel 0 is not forwarded. Same with mem_address_error=1 → 0. Same with exec_part=1 → 0.
